writeback_unit: RTL
===================

# writeback_unit

Final stage of the KGP-miniRISC datapath, directly upstream of the register file. Accepts retired instructions (ALU result, link/return address, or pending load) over a valid/ready handshake. Waits for load data where needed and drives the register file write port (`reg_write`, `data_write`) plus a destination index for exactly one cycle per write. Also exports a bypass tap for operand forwarding and flags load timeouts.

## Interface
- `DATA_W`, 32, datapath width
- `IDX_W`, 5, register index width
- `LINK_REG`, 31, register written by link ops
- `TIMEOUT`, 15, max cycles waited for load data
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `in_valid`  in  1  upstream offers an instruction
- `in_ready`  out  1  unit can accept this cycle
- `in_op`  in  2  00 retire-no-write, 01 link, 10 ALU result, 11 load
- `in_dest`  in  IDX_W  destination register (ignored for 00/01)
- `in_data`  in  DATA_W  ALU result or return address
- `mem_rvalid`  in  1  load data valid
- `mem_rdata`  in  DATA_W  load data
- `reg_write`  out  2  to register file: 00 none, 01 write LINK_REG, 10 write `wb_index`; 11 never driven
- `wb_index`  out  IDX_W  destination for code 10
- `data_write`  out  DATA_W  write data
- `fwd_valid`  out  1  a write is on the port this cycle
- `fwd_index`  out  IDX_W  register being written (LINK_REG for link)
- `fwd_data`  out  DATA_W  equals `data_write`
- `load_err`  out  1  sticky load-timeout flag

## Operation
- States: IDLE, LOAD_WAIT, COMMIT.
- `in_ready` = 1 in IDLE and COMMIT, 0 in LOAD_WAIT.
- Accept = `in_valid & in_ready` at a rising edge.
- On accept:
  - op 00: next state IDLE, no write.
  - op 01: latch `in_data`, code 01 → COMMIT.
  - op 10: latch `in_data`, `in_dest`; code 10 → COMMIT.
  - op 11: latch `in_dest`, clear timeout counter → LOAD_WAIT.
- op 10/11 with `in_dest` = 0: R0 is never written. Code forced to 00, instruction still retires.
- LOAD_WAIT:
  - `mem_rvalid` = 1 → latch `mem_rdata`, code 10 → COMMIT.
  - Else counter increments. On reaching TIMEOUT → set `load_err`, return to IDLE, no write.
- COMMIT lasts exactly one cycle, then moves to the state chosen by any simultaneous accept (else IDLE). Back-to-back ALU ops sustain one write per cycle.
- Outside COMMIT: `reg_write` = 00, `fwd_valid` = 0.
- `mem_rvalid` outside LOAD_WAIT, including the accept cycle of the load, is ignored.
- `load_err` is cleared only by reset.

## Timing
- All outputs registered except `in_ready`, which is decoded from state.
- Reset values: state IDLE, `reg_write` 00, `wb_index` 0, `data_write` 0, `fwd_*` 0, `load_err` 0, counter 0. `in_ready` = 1 once reset releases.
- ALU/link op accepted at edge k → write visible during cycle k..k+1 → register file captures at edge k+1.
- Load: `mem_rvalid` sampled at edge m → write visible after m → captured at edge m+1.
- Minimum load latency: 2 edges after accept.
- Timeout: `load_err` rises at the edge where the counter hits TIMEOUT with no `mem_rvalid`. If `mem_rvalid` arrives on that same edge, data wins and no error is raised.
- Reset asserted mid-LOAD_WAIT or mid-COMMIT: pending write is dropped immediately and asynchronously; no partial write is ever presented.

## Structure
- Shared package `minirisc_pkg`:
  - op codes (`OP_NONE`, `OP_LINK`, `OP_ALU`, `OP_LOAD`)
  - `reg_write` codes (`RW_NONE`, `RW_LINK`, `RW_IDX`)
  - `LINK_REG`
  - state enum
- Single module; the timeout counter is inline. No sub-module required.

## Test plan
- Reset, then op 10, dest 5, data 16 → cycle after accept: `reg_write` 10, `wb_index` 5, `data_write` 16, `fwd_valid` 1; next cycle `reg_write` 00.
- Op 01, data 9, then op 10, dest 1, data 20 on consecutive edges → two consecutive commit cycles: (01, 9, `fwd_index` 31) then (10, idx 1, 20).
- Op 11, dest 3; `mem_rvalid` with 22 three cycles later → `in_ready` 0 while waiting; then one cycle of `reg_write` 10, idx 3, data 22.
- Op 11 with no `mem_rvalid` → `load_err` = 1 after 15 cycles, no write, `in_ready` returns to 1.
- Op 10, dest 0, data 7 → `reg_write` stays 00; `rst` low during LOAD_WAIT → all outputs zero, IDLE, no write after release.

Source files
------------

// File: rtl/minirisc_pkg.sv
// rtl/minirisc_pkg.sv - shared KGP-miniRISC types for the writeback stage
// Contents:
//   op_e     : retired-instruction op codes carried on in_op
//   rw_e     : register-file write-port codes driven on reg_write
//   LINK_REG : register written by link ops
//   wb_state_e : writeback FSM states
package minirisc_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_LINK = 2'b01,
        OP_ALU  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    // Code 2'b11 exists on the wire but is never driven.
    typedef enum logic [1:0] {
        RW_NONE = 2'b00,
        RW_LINK = 2'b01,
        RW_IDX  = 2'b10
    } rw_e;

    localparam int LINK_REG = 31;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        COMMIT    = 2'b10
    } wb_state_e;

endpackage

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - final datapath stage driving the register file write port
// Ports:
//   clk, rst               : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      : retired-instruction handshake (accept = valid & ready)
//   in_op, in_dest, in_data: op code, destination register, ALU result / return address
//   mem_rvalid, mem_rdata  : load data return
//   reg_write, wb_index,
//   data_write             : register file write port, one cycle per write
//   fwd_valid, fwd_index,
//   fwd_data               : bypass tap mirroring the write port
//   load_err               : sticky load-timeout flag
module writeback_unit
    import minirisc_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 5,
    parameter int LINK_REG = minirisc_pkg::LINK_REG,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [IDX_W-1:0]  in_dest,
    input  logic [DATA_W-1:0] in_data,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        reg_write,
    output logic [IDX_W-1:0]  wb_index,
    output logic [DATA_W-1:0] data_write,
    output logic              fwd_valid,
    output logic [IDX_W-1:0]  fwd_index,
    output logic [DATA_W-1:0] fwd_data,
    output logic              load_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LINK_IDX = IDX_W'(LINK_REG);

    wb_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  dest_q, dest_d;
    rw_e               rw_q, rw_d;
    logic [IDX_W-1:0]  wb_idx_q, wb_idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fwd_valid_q, fwd_valid_d;
    logic [IDX_W-1:0]  fwd_idx_q, fwd_idx_d;
    logic              err_q, err_d;

    logic accept;
    op_e  op;

    assign in_ready = (state_q != LOAD_WAIT);
    assign accept   = in_valid & in_ready;
    assign op       = op_e'(in_op);

    // State register and all registered outputs. Reset drops any pending
    // write immediately, so no partial write ever reaches the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dest_q      <= '0;
            rw_q        <= RW_NONE;
            wb_idx_q    <= '0;
            data_q      <= '0;
            fwd_valid_q <= 1'b0;
            fwd_idx_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dest_q      <= dest_d;
            rw_q        <= rw_d;
            wb_idx_q    <= wb_idx_d;
            data_q      <= data_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_idx_q   <= fwd_idx_d;
            err_q       <= err_d;
        end
    end

    // Next-state decode. COMMIT behaves like IDLE for acceptance, which is
    // what lets back-to-back ALU ops produce one write per cycle.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            LOAD_WAIT: begin
                if (mem_rvalid) begin
                    // A load into R0 retires without a write cycle.
                    state_d = (dest_q != '0) ? COMMIT : IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOAD_WAIT;
                end
            end
            default: begin
                if (accept) begin
                    case (op)
                        OP_LINK: state_d = COMMIT;
                        OP_ALU:  state_d = (in_dest != '0) ? COMMIT : IDLE;
                        OP_LOAD: state_d = LOAD_WAIT;
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    // Next values of the write port, forwarding tap, load bookkeeping and
    // error flag. Write fields are zero on every cycle without a write.
    always_comb begin
        cnt_d       = cnt_q;
        dest_d      = dest_q;
        rw_d        = RW_NONE;
        wb_idx_d    = '0;
        data_d      = '0;
        fwd_valid_d = 1'b0;
        fwd_idx_d   = '0;
        err_d       = err_q;
        case (state_q)
            LOAD_WAIT: begin
                if (mem_rvalid) begin
                    // Data arriving on the timeout edge still wins.
                    if (dest_q != '0) begin
                        rw_d        = RW_IDX;
                        wb_idx_d    = dest_q;
                        data_d      = mem_rdata;
                        fwd_valid_d = 1'b1;
                        fwd_idx_d   = dest_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                if (accept) begin
                    case (op)
                        OP_LINK: begin
                            rw_d        = RW_LINK;
                            data_d      = in_data;
                            fwd_valid_d = 1'b1;
                            fwd_idx_d   = LINK_IDX;
                        end
                        OP_ALU: begin
                            if (in_dest != '0) begin
                                rw_d        = RW_IDX;
                                wb_idx_d    = in_dest;
                                data_d      = in_data;
                                fwd_valid_d = 1'b1;
                                fwd_idx_d   = in_dest;
                            end
                        end
                        OP_LOAD: begin
                            dest_d = in_dest;
                            cnt_d  = '0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    assign reg_write  = rw_q;
    assign wb_index   = wb_idx_q;
    assign data_write = data_q;
    assign fwd_valid  = fwd_valid_q;
    assign fwd_index  = fwd_idx_q;
    assign fwd_data   = data_q;
    assign load_err   = err_q;

endmodule
